// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e : sequencing FSM states
//   IDX_W       : width of a domain index (up to 8 domains)
//   cnt_width() : width of the shared hold/delay/timeout counter
package reset_seq_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    HOLD,
    DELAY,
    WAIT_READY,
    DONE,
    ERROR
  } seq_state_e;

  // The counter needs room for the largest terminal value plus one spare bit,
  // so it can never wrap before the terminal compare fires.
  function automatic int cnt_width(int hold_cycles, int timeout, int delay_w);
    int w;
    w = delay_w;
    if ($clog2(hold_cycles) > w) w = $clog2(hold_cycles);
    if ($clog2(timeout) > w) w = $clog2(timeout);
    return w + 1;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable up-counter with a terminal-compare output. One instance is shared by
// the HOLD, DELAY and WAIT_READY phases of the reset sequencer.
// Ports:
//   clock    : rising-edge clock
//   clear    : synchronous clear to zero (highest priority)
//   load     : synchronous load of load_val
//   load_val : value loaded when load is high
//   enable   : count up by one
//   term_val : terminal value to compare against
//   term     : high while the count equals term_val
module reset_seq_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  input  logic [CNT_W-1:0] term_val,
  output logic             term
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == term_val);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release controller. All domain resets are held for HOLD_CYCLES,
// then domains are released one at a time in index order. Each release waits a
// programmable per-domain delay and then waits for that domain's ready ack; a
// missing ack within TIMEOUT cycles parks the sequencer in a sticky error.
// Ports:
//   clock          : system clock, all logic on the rising edge
//   reset          : synchronous active-high block reset
//   soft_reset_req : one-cycle pulse that restarts the full sequence
//   cfg_wr_en      : delay register write strobe
//   cfg_wr_idx     : domain index of the write (out-of-range writes ignored)
//   cfg_wr_delay   : delay value written
//   domain_ready   : per-domain ready acknowledge
//   domain_reset_n : registered active-low reset per domain
//   seq_busy       : sequencing in progress (HOLD/DELAY/WAIT_READY)
//   seq_done       : all domains released and acknowledged
//   timeout_err    : sticky ready-timeout error
//   err_idx        : domain that timed out, valid with timeout_err
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS   = 4,
  parameter int DELAY_W       = 8,
  parameter int DEFAULT_DELAY = 16,
  parameter int HOLD_CYCLES   = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  input  logic                   cfg_wr_en,
  input  logic [IDX_W-1:0]       cfg_wr_idx,
  input  logic [DELAY_W-1:0]     cfg_wr_delay,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [IDX_W-1:0]       err_idx
);

  localparam int               CNT_W     = cnt_width(HOLD_CYCLES, TIMEOUT, DELAY_W);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   load_idx;
  logic [DELAY_W-1:0] delay_q [NUM_DOMAINS];
  logic [DELAY_W-1:0] dly_q;
  logic [DELAY_W-1:0] dly_sel;
  logic               ready_sel;
  logic               tmr_clear;
  logic               tmr_en;
  logic               tmr_term;
  logic [CNT_W-1:0]   term_val;

  // Delay register file. Writes land at the same edge the FSM may latch a
  // value into dly_q, so a write coinciding with DELAY entry only affects the
  // next sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        delay_q[i] <= DELAY_W'(DEFAULT_DELAY);
      end
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (cfg_wr_idx == IDX_W'(i)) begin
          delay_q[i] <= cfg_wr_delay;
        end
      end
    end
  end

  // Index muxes and shared-timer control. load_idx is the domain whose DELAY
  // phase starts next: 0 when leaving HOLD, idx+1 when leaving WAIT_READY.
  always_comb begin
    load_idx  = (state == HOLD) ? '0 : idx + IDX_W'(1);
    dly_sel   = '0;
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (load_idx == IDX_W'(i)) dly_sel = delay_q[i];
      if (idx == IDX_W'(i))      ready_sel = domain_ready[i];
    end

    case (state)
      HOLD:    term_val = HOLD_TERM;
      DELAY:   term_val = CNT_W'(dly_q);
      default: term_val = WAIT_TERM;
    endcase

    tmr_en    = (state == HOLD) || (state == DELAY) || (state == WAIT_READY);
    tmr_clear = reset || soft_reset_req
             || ((state == HOLD)       && tmr_term)
             || ((state == DELAY)      && tmr_term)
             || ((state == WAIT_READY) && ready_sel);
  end

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .clear    (tmr_clear),
    .load     (1'b0),
    .load_val ('0),
    .enable   (tmr_en),
    .term_val (term_val),
    .term     (tmr_term)
  );

  // Sequencing FSM with registered outputs. Priority: reset, then
  // soft_reset_req, then the normal advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= HOLD;
      idx            <= '0;
      domain_reset_n <= '0;
      seq_busy       <= 1'b1;
      seq_done       <= 1'b0;
      timeout_err    <= 1'b0;
      err_idx        <= '0;
    end else if (soft_reset_req) begin
      state          <= HOLD;
      idx            <= '0;
      domain_reset_n <= '0;
      seq_busy       <= 1'b1;
      seq_done       <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (tmr_term) begin
            state <= DELAY;
            idx   <= '0;
            dly_q <= dly_sel;
          end
        end

        DELAY: begin
          if (tmr_term) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx == IDX_W'(i)) domain_reset_n[i] <= 1'b1;
            end
            state <= WAIT_READY;
          end
        end

        WAIT_READY: begin
          if (ready_sel) begin
            if (idx == LAST_IDX) begin
              state          <= DONE;
              seq_busy       <= 1'b0;
              seq_done       <= 1'b1;
              domain_reset_n <= '1;
            end else begin
              idx   <= load_idx;
              dly_q <= dly_sel;
              state <= DELAY;
            end
          end else if (tmr_term) begin
            // The domain that never acknowledged is put back into reset so
            // that only fully acknowledged domains remain running.
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx == IDX_W'(i)) domain_reset_n[i] <= 1'b0;
            end
            state       <= ERROR;
            seq_busy    <= 1'b0;
            timeout_err <= 1'b1;
            err_idx     <= idx;
          end
        end

        DONE, ERROR: begin
        end

        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a cycle-level reference model compared on
// every cycle, plus hand-computed expectations at key cycles.
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int DEF  = 16;
  localparam int HOLD = 32;
  localparam int TMO  = 255;

  localparam int PH_HOLD  = 0;
  localparam int PH_DELAY = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_DONE  = 3;
  localparam int PH_ERR   = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset_req = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic [2:0]    cfg_wr_idx = '0;
  logic [DW-1:0] cfg_wr_delay = '0;
  logic [N-1:0]  domain_ready = '0;
  logic [N-1:0]  domain_reset_n;
  logic          seq_busy;
  logic          seq_done;
  logic          timeout_err;
  logic [2:0]    err_idx;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NUM_DOMAINS   (N),
    .DELAY_W       (DW),
    .DEFAULT_DELAY (DEF),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT       (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .soft_reset_req (soft_reset_req),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_idx     (cfg_wr_idx),
    .cfg_wr_delay   (cfg_wr_delay),
    .domain_ready   (domain_ready),
    .domain_reset_n (domain_reset_n),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err),
    .err_idx        (err_idx)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready responder: each domain acknowledges 2 cycles after its release,
  // unless its bit in ready_block is set.
  logic [N-1:0] ready_block = '0;
  logic [N-1:0] h1 = '0, h2 = '0, h3 = '0;
  always @(negedge clock) begin
    h3 = h2;
    h2 = h1;
    h1 = domain_reset_n;
    domain_ready = h3 & ~ready_block;
  end

  // Reference model: phase plus a countdown of cycles left in the phase.
  bit           m_valid = 0;
  int           m_phase = PH_HOLD;
  int           m_left  = HOLD;
  int           m_idx   = 0;
  int           m_eidx  = 0;
  logic [N-1:0] m_rel   = '0;
  int           m_dly [N];

  always @(posedge clock) begin
    int old_dly [N];
    old_dly = m_dly;
    if (reset) begin
      m_valid = 1;
      cyc     = 0;
      m_phase = PH_HOLD;
      m_left  = HOLD;
      m_idx   = 0;
      m_eidx  = 0;
      m_rel   = '0;
      foreach (m_dly[i]) m_dly[i] = DEF;
    end else begin
      cyc++;
      if (cfg_wr_en && cfg_wr_idx < N) m_dly[cfg_wr_idx] = cfg_wr_delay;
      if (soft_reset_req) begin
        cyc     = 0;
        m_phase = PH_HOLD;
        m_left  = HOLD;
        m_idx   = 0;
        m_rel   = '0;
      end else begin
        case (m_phase)
          PH_HOLD: begin
            m_left--;
            if (m_left == 0) begin
              m_phase = PH_DELAY;
              m_idx   = 0;
              m_left  = old_dly[0] + 1;
            end
          end
          PH_DELAY: begin
            m_left--;
            if (m_left == 0) begin
              m_rel[m_idx] = 1'b1;
              m_phase      = PH_WAIT;
              m_left       = TMO;
            end
          end
          PH_WAIT: begin
            if (domain_ready[m_idx]) begin
              if (m_idx == N - 1) begin
                m_phase = PH_DONE;
              end else begin
                m_idx++;
                m_phase = PH_DELAY;
                m_left  = old_dly[m_idx] + 1;
              end
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_phase      = PH_ERR;
                m_eidx       = m_idx;
                m_rel[m_idx] = 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_rst_n", 32'(domain_reset_n), 32'(m_rel));
      check("model_busy", 32'(seq_busy), 32'(m_phase <= PH_WAIT));
      check("model_done", 32'(seq_done), 32'(m_phase == PH_DONE));
      check("model_terr", 32'(timeout_err), 32'(m_phase == PH_ERR));
      if (m_phase == PH_ERR) check("model_err_idx", 32'(err_idx), 32'(m_eidx));
    end
  end

  task automatic wait_cyc(input int n);
    for (int k = 0; k < 2000 && cyc != n; k++) @(negedge clock);
    if (cyc != n) check("wait_cyc_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] i, input logic [DW-1:0] d);
    cfg_wr_en    = 1'b1;
    cfg_wr_idx   = i;
    cfg_wr_delay = d;
    @(negedge clock);
    cfg_wr_en = 1'b0;
  endtask

  task automatic soft_pulse();
    soft_reset_req = 1'b1;
    @(negedge clock);
    soft_reset_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    // Power-up with defaults.
    @(negedge clock);
    do_reset();
    check("rst_state_rst_n", 32'(domain_reset_n), 32'h0);
    check("rst_state_busy", 32'(seq_busy), 32'h1);
    check("rst_state_done", 32'(seq_done), 32'h0);
    check("rst_state_terr", 32'(timeout_err), 32'h0);
    check("rst_state_err_idx", 32'(err_idx), 32'h0);
    wait_cyc(31);  check("t1_hold_end", 32'(domain_reset_n), 32'h0);
    wait_cyc(48);  check("t1_bit0_pre", 32'(domain_reset_n), 32'h0);
    wait_cyc(49);  check("t1_bit0", 32'(domain_reset_n), 32'h1);
    wait_cyc(68);  check("t1_bit1_pre", 32'(domain_reset_n), 32'h1);
    wait_cyc(69);  check("t1_bit1", 32'(domain_reset_n), 32'h3);
    wait_cyc(89);  check("t1_bit2", 32'(domain_reset_n), 32'h7);
    wait_cyc(109); check("t1_bit3", 32'(domain_reset_n), 32'hF);
    wait_cyc(111); check("t1_done_pre", 32'(seq_done), 32'h0);
    wait_cyc(112); check("t1_done", 32'(seq_done), 32'h1);
    check("t1_busy_done", 32'(seq_busy), 32'h0);
    ready_block = '1;
    repeat (6) @(negedge clock);
    check("t1_done_ready_drop", 32'({seq_done, domain_reset_n}), 32'h1F);
    ready_block = '0;

    // Config writes before the sequence; out-of-range index ignored.
    do_reset();
    cfg_write(3'd2, 8'd0);
    cfg_write(3'd1, 8'd5);
    cfg_write(3'd4, 8'd0);
    wait_cyc(49); check("t2_bit0", 32'(domain_reset_n), 32'h1);
    wait_cyc(57); check("t2_bit1_pre", 32'(domain_reset_n), 32'h1);
    wait_cyc(58); check("t2_bit1", 32'(domain_reset_n), 32'h3);
    wait_cyc(61); check("t2_bit2_pre", 32'(domain_reset_n), 32'h3);
    wait_cyc(62); check("t2_bit2", 32'(domain_reset_n), 32'h7);
    wait_cyc(82); check("t2_bit3", 32'(domain_reset_n), 32'hF);

    // Timeout on domain 1, then recovery by soft reset.
    do_reset();
    ready_block = 4'b0010;
    wait_cyc(69);  check("t3_bit1", 32'(domain_reset_n), 32'h3);
    wait_cyc(323); check("t3_terr_pre", 32'(timeout_err), 32'h0);
    wait_cyc(324); check("t3_terr", 32'(timeout_err), 32'h1);
    check("t3_err_idx", 32'(err_idx), 32'h1);
    check("t3_rst_n", 32'(domain_reset_n), 32'h1);
    wait_cyc(330); check("t3_sticky", 32'(timeout_err), 32'h1);
    soft_pulse();
    check("t3_soft_rst_n", 32'(domain_reset_n), 32'h0);
    check("t3_soft_terr", 32'(timeout_err), 32'h0);
    check("t3_soft_busy", 32'(seq_busy), 32'h1);
    ready_block = '0;

    // Soft reset in the middle of DELAY(2); written delays survive it.
    cfg_write(3'd1, 8'd5);
    cfg_write(3'd2, 8'd10);
    wait_cyc(65); check("t4_mid_delay2", 32'(domain_reset_n), 32'h3);
    soft_pulse();
    check("t4_soft_rst_n", 32'(domain_reset_n), 32'h0);
    wait_cyc(58); check("t4_rerun_bit1", 32'(domain_reset_n), 32'h3);
    wait_cyc(72); check("t4_rerun_bit2", 32'(domain_reset_n), 32'h7);
    wait_cyc(95); check("t4_rerun_done", 32'(seq_done), 32'h1);

    // Reset together with soft reset during WAIT_READY(3).
    ready_block = 4'b1000;
    soft_pulse();
    wait_cyc(92); check("t5_bit3", 32'(domain_reset_n), 32'hF);
    wait_cyc(100);
    reset = 1'b1;
    soft_reset_req = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    soft_reset_req = 1'b0;
    ready_block = '0;
    check("t5_rst_n", 32'(domain_reset_n), 32'h0);
    check("t5_busy", 32'(seq_busy), 32'h1);
    check("t5_done", 32'(seq_done), 32'h0);
    check("t5_err_idx", 32'(err_idx), 32'h0);
    wait_cyc(49);  check("t5_bit0_default", 32'(domain_reset_n), 32'h1);
    wait_cyc(69);  check("t5_bit1_default", 32'(domain_reset_n), 32'h3);
    wait_cyc(109); check("t5_bit3", 32'(domain_reset_n), 32'hF);
    wait_cyc(112); check("t5_done", 32'(seq_done), 32'h1);

    // Write to delay[2] in the cycle DELAY(2) is entered.
    soft_pulse();
    wait_cyc(71);
    cfg_write(3'd2, 8'd2);
    wait_cyc(88);  check("t6_old_delay_pre", 32'(domain_reset_n), 32'h3);
    wait_cyc(89);  check("t6_old_delay", 32'(domain_reset_n), 32'h7);
    wait_cyc(112); check("t6_done", 32'(seq_done), 32'h1);
    soft_pulse();
    wait_cyc(74);  check("t6_new_delay_pre", 32'(domain_reset_n), 32'h3);
    wait_cyc(75);  check("t6_new_delay", 32'(domain_reset_n), 32'h7);
    wait_cyc(95);  check("t6_bit3", 32'(domain_reset_n), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
